alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
Parametrised successor of the single-cycle ALU. It executes the full RV32I ALU operation set plus the RV32M multiply/divide operations behind a valid/ready handshake. Simple operations return a registered result one cycle after acceptance. MUL*/DIV*/REM* run on an iterative shift-add / restoring-divide core. It sits between decode and memory in the execute stage and raises o_Busy_1 so the pipeline can stall.

Parameters:
XLEN, 32, datapath width; must be a power of 2 and at least 8.
SHW, $clog2(XLEN), shift-amount width; derived, must not be overridden.

Ports:
i_Clk_1  in  1  clock; all state updates on the rising edge.
i_Rst_1  in  1  reset, asynchronous, active-high.
i_Flush_1  in  1  abort the operation in flight and drop any pending result.
i_Valid_1  in  1  operation request.
o_Ready_1  out  1  block can accept a request (high only in IDLE).
i_ALUControl_20  in  20  one-hot op: ADD,PC4,SUB,SLT,SLTU,AND,OR,XOR,SLL,SRL,SRA,LUI,MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU (MSB first).
i_PC  in  XLEN  instruction PC.
i_ALUOperand1  in  XLEN  operand 1.
i_ALUOperand2  in  XLEN  operand 2.
o_Valid_1  out  1  result valid.
i_ResultReady_1  in  1  consumer accepts the result.
o_ALUResult  out  XLEN  registered result.
o_JumpBranchAddr  out  XLEN  registered operand1+operand2, captured at acceptance.
o_PCPlus4  out  XLEN  registered i_PC+4, captured at acceptance.
o_Busy_1  out  1  high in CALC, or in DONE while the result is not yet taken.

Behaviour:
- Reset (asynchronous, active-high, valid at any time including mid-operation):
  - state=IDLE; all outputs 0 except o_Ready_1=1.
  - Counter and iterative registers are cleared.
- States: IDLE, CALC, DONE.
- Acceptance occurs on a rising edge in IDLE with i_Valid_1=1. Operands, control, PC+4 and the sum are captured on that edge.
- Simple ops (ADD..LUI), zero-operand-2 divides, and divide overflow: IDLE→DONE. o_Valid_1 rises 1 cycle after acceptance.
- Iterative ops: IDLE→CALC. The counter loads XLEN-1 and decrements once per cycle; at 0, CALC→DONE. o_Valid_1 rises XLEN+1 cycles after acceptance.
- DONE: o_Valid_1=1 and o_ALUResult stays stable until i_ResultReady_1=1.
  - On that edge: DONE→IDLE and o_Valid_1=0.
  - A new request cannot be accepted on the same edge; the next acceptance is one cycle later.
- i_Flush_1 has priority over everything except reset. From any state it forces IDLE on the next edge with o_Valid_1=0. A flush in IDLE together with i_Valid_1 means the request is not accepted.
- Shifts use only operand2[SHW-1:0]; SRA is arithmetic.
- SLT is signed (two's complement); SLTU is unsigned; both return a 0/1 result in bit 0.
- LUI returns operand2; PC4 returns PC+4.
- Multiply:
  - Operands are converted to magnitudes according to signedness (MULHSU: op1 signed, op2 unsigned).
  - An unsigned 2*XLEN product is formed over XLEN shift-add steps and negated at DONE if the signs differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide uses a restoring algorithm on magnitudes. The quotient sign is sign1^sign2; the remainder takes the sign of the dividend.
- Divide by zero takes one cycle: DIV/DIVU return all ones; REM/REMU return the dividend.
- Signed overflow takes one cycle: -2^(XLEN-1) / -1 gives DIV = dividend and REM = 0.
- A control word that is zero or has more than one bit set takes one cycle and returns o_ALUResult=0.
- Operand changes after acceptance have no effect.

Decomposition:
- Package alu_pkg holds:
  - localparams for the 20 control bit indices;
  - a state enum (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - op-class helper functions (is_mul, is_div, is_signed_op1, is_signed_op2, wants_high).
- One sub-module, muldiv_iter, contains the counter, accumulator/remainder and shift registers, with start/done pins. The top level keeps the FSM, the simple-op datapath, and the result muxing.

Test Plan:
- ADD 7+9, SUB 3-5, SRA 0x80000000 with op2=0x21, SLTU 1<0xFFFFFFFF → results 16, 0xFFFFFFFE, 0xC0000000, 1; each with o_Valid_1 exactly 1 cycle after acceptance.
- MULH 0x80000000*0x80000000 → 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE; MUL 0xFFFFFFFF*3 → 0xFFFFFFFD; o_Valid_1 at acceptance+33 cycles.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both 1-cycle; DIV 0x80000000/0xFFFFFFFF → 0x80000000, 1-cycle; REM of the same → 0.
- Hold i_ResultReady_1=0 for 10 cycles in DONE → o_ALUResult and o_Valid_1 stable, o_Ready_1=0, o_Busy_1=1; then accept → IDLE with o_Ready_1=1 the next cycle.
- Assert i_Flush_1 at CALC cycle 12, and separately assert i_Rst_1 asynchronously mid-CALC → o_Valid_1 never rises, o_Ready_1=1 (flush: next edge; reset: immediately), and the next ADD 1+1 → 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control bit positions, FSM
// states and op-class decode helpers.
package alu_pkg;

    localparam int NUM_OPS = 20;

    localparam int OP_ADD    = 19;
    localparam int OP_PC4    = 18;
    localparam int OP_SUB    = 17;
    localparam int OP_SLT    = 16;
    localparam int OP_SLTU   = 15;
    localparam int OP_AND    = 14;
    localparam int OP_OR     = 13;
    localparam int OP_XOR    = 12;
    localparam int OP_SLL    = 11;
    localparam int OP_SRL    = 10;
    localparam int OP_SRA    = 9;
    localparam int OP_LUI    = 8;
    localparam int OP_MUL    = 7;
    localparam int OP_MULH   = 6;
    localparam int OP_MULHSU = 5;
    localparam int OP_MULHU  = 4;
    localparam int OP_DIV    = 3;
    localparam int OP_DIVU   = 2;
    localparam int OP_REM    = 1;
    localparam int OP_REMU   = 0;

    typedef logic [NUM_OPS-1:0] ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Per-operation setup for the iterative core. neg_lo negates the product
    // (multiply) or the quotient (divide); neg_hi negates the remainder.
    typedef struct packed {
        logic is_div;
        logic neg_lo;
        logic neg_hi;
        logic sel_hi;
    } muldiv_cfg_t;

    localparam ctrl_t MUL_OPS  = ctrl_t'((1 << OP_MUL) | (1 << OP_MULH) | (1 << OP_MULHSU) | (1 << OP_MULHU));
    localparam ctrl_t DIV_OPS  = ctrl_t'((1 << OP_DIV) | (1 << OP_DIVU) | (1 << OP_REM) | (1 << OP_REMU));
    localparam ctrl_t SGN1_OPS = ctrl_t'((1 << OP_MUL) | (1 << OP_MULH) | (1 << OP_MULHSU) | (1 << OP_DIV) | (1 << OP_REM));
    localparam ctrl_t SGN2_OPS = ctrl_t'((1 << OP_MUL) | (1 << OP_MULH) | (1 << OP_DIV) | (1 << OP_REM));
    // Upper half of the result pair: product high word or remainder.
    localparam ctrl_t HIGH_OPS = ctrl_t'((1 << OP_MULH) | (1 << OP_MULHSU) | (1 << OP_MULHU) | (1 << OP_REM) | (1 << OP_REMU));

    function automatic logic is_mul(input ctrl_t c);
        return |(c & MUL_OPS);
    endfunction

    function automatic logic is_div(input ctrl_t c);
        return |(c & DIV_OPS);
    endfunction

    function automatic logic is_signed_op1(input ctrl_t c);
        return |(c & SGN1_OPS);
    endfunction

    function automatic logic is_signed_op2(input ctrl_t c);
        return |(c & SGN2_OPS);
    endfunction

    function automatic logic wants_high(input ctrl_t c);
        return |(c & HIGH_OPS);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative magnitude core: shift-add multiply or restoring divide, one step
// per cycle over XLEN steps, sign fix-up applied on the way out.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              gclk,
    input  logic              grst,
    input  logic              clear,
    input  logic              start,
    input  muldiv_cfg_t       cfg,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic [XLEN-1:0]   result
);

    localparam int CW = $clog2(XLEN);

    logic              busy_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q;
    muldiv_cfg_t       cfg_q;

    logic              cur_div;
    logic [XLEN-1:0]   cur_hi, cur_lo, cur_b, nxt_hi, nxt_lo, quo, rem;
    logic [XLEN:0]     add_sum, shifted, trial;
    logic [2*XLEN-1:0] prod;

    // The first step is taken on the start edge straight from the inputs,
    // so XLEN steps finish with the counter at zero.
    always_comb begin
        cur_hi  = start ? '0 : hi_q;
        cur_lo  = start ? a : lo_q;
        cur_b   = start ? b : opnd_q;
        cur_div = start ? cfg.is_div : cfg_q.is_div;
        add_sum = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
        shifted = {cur_hi, cur_lo[XLEN-1]};
        trial   = shifted - {1'b0, cur_b};
        if (cur_div) begin
            nxt_hi = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            nxt_lo = {cur_lo[XLEN-2:0], ~trial[XLEN]};
        end else begin
            {nxt_hi, nxt_lo} = {add_sum, cur_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cfg_q  <= '0;
        end else if (clear) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(XLEN-1);
            hi_q   <= nxt_hi;
            lo_q   <= nxt_lo;
            opnd_q <= b;
            cfg_q  <= cfg;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
                hi_q  <= nxt_hi;
                lo_q  <= nxt_lo;
            end
        end
    end

    assign done = busy_q && (cnt_q == '0);

    always_comb begin
        prod = cfg_q.neg_lo ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo  = cfg_q.neg_lo ? -lo_q : lo_q;
        rem  = cfg_q.neg_hi ? -hi_q : hi_q;
        if (cfg_q.is_div)
            result = cfg_q.sel_hi ? rem : quo;
        else
            result = cfg_q.sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with RV32M extension: single-cycle simple ops, iterative
// multiply/divide, valid/ready on both request and result sides.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_Clk_1,
    input  logic            i_Rst_1,
    input  logic            i_Flush_1,
    input  logic            i_Valid_1,
    output logic            o_Ready_1,
    input  logic [19:0]     i_ALUControl_20,
    input  logic [XLEN-1:0] i_PC,
    input  logic [XLEN-1:0] i_ALUOperand1,
    input  logic [XLEN-1:0] i_ALUOperand2,
    output logic            o_Valid_1,
    input  logic            i_ResultReady_1,
    output logic [XLEN-1:0] o_ALUResult,
    output logic [XLEN-1:0] o_JumpBranchAddr,
    output logic [XLEN-1:0] o_PCPlus4,
    output logic            o_Busy_1
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    ctrl_t           ctrl;
    logic [XLEN-1:0] op1, op2, sum, pc4, simple_res, special_res, short_res;
    logic [XLEN-1:0] mag1, mag2, core_res;
    logic [SHW-1:0]  shamt;
    logic            one_hot, sign1, sign2, div0, ovf, iterative;
    logic            accept, core_done, finish;
    muldiv_cfg_t     cfg;

    assign ctrl  = i_ALUControl_20;
    assign op1   = i_ALUOperand1;
    assign op2   = i_ALUOperand2;
    assign shamt = op2[SHW-1:0];
    assign sum   = op1 + op2;
    assign pc4   = i_PC + XLEN'(4);

    assign one_hot = (ctrl != '0) && ((ctrl & (ctrl - ctrl_t'(1))) == '0);

    // Only valid when one_hot holds, so the ORed terms never overlap.
    always_comb begin
        simple_res = '0;
        if (ctrl[OP_ADD])  simple_res = sum;
        if (ctrl[OP_PC4])  simple_res = pc4;
        if (ctrl[OP_SUB])  simple_res = op1 - op2;
        if (ctrl[OP_SLT])  simple_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
        if (ctrl[OP_SLTU]) simple_res = {{(XLEN-1){1'b0}}, op1 < op2};
        if (ctrl[OP_AND])  simple_res = op1 & op2;
        if (ctrl[OP_OR])   simple_res = op1 | op2;
        if (ctrl[OP_XOR])  simple_res = op1 ^ op2;
        if (ctrl[OP_SLL])  simple_res = op1 << shamt;
        if (ctrl[OP_SRL])  simple_res = op1 >> shamt;
        if (ctrl[OP_SRA])  simple_res = $signed(op1) >>> shamt;
        if (ctrl[OP_LUI])  simple_res = op2;
    end

    assign sign1 = is_signed_op1(ctrl) && op1[XLEN-1];
    assign sign2 = is_signed_op2(ctrl) && op2[XLEN-1];
    assign mag1  = sign1 ? -op1 : op1;
    assign mag2  = sign2 ? -op2 : op2;

    assign div0 = is_div(ctrl) && (op2 == '0);
    assign ovf  = (ctrl[OP_DIV] || ctrl[OP_REM]) && (op1 == MIN_NEG) && (op2 == '1);
    assign special_res = div0 ? ((ctrl[OP_DIV] || ctrl[OP_DIVU]) ? '1 : op1)
                              : (ctrl[OP_DIV] ? op1 : '0);
    assign short_res   = !one_hot ? '0 : ((div0 || ovf) ? special_res : simple_res);
    assign iterative   = one_hot && (is_mul(ctrl) || (is_div(ctrl) && !div0 && !ovf));

    assign cfg = '{is_div: is_div(ctrl), neg_lo: sign1 ^ sign2, neg_hi: sign1, sel_hi: wants_high(ctrl)};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (i_Flush_1) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (i_Valid_1) begin
                    accept  = 1'b1;
                    state_d = iterative ? CALC : DONE;
                end
                CALC: if (core_done) state_d = DONE;
                DONE: if (i_ResultReady_1) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign finish = (state_q == CALC) && core_done && !i_Flush_1;

    always_ff @(posedge i_Clk_1 or posedge i_Rst_1) begin
        if (i_Rst_1) begin
            state_q          <= IDLE;
            o_ALUResult      <= '0;
            o_JumpBranchAddr <= '0;
            o_PCPlus4        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                o_JumpBranchAddr <= sum;
                o_PCPlus4        <= pc4;
                if (!iterative) o_ALUResult <= short_res;
            end else if (finish) begin
                o_ALUResult <= core_res;
            end
        end
    end

    assign o_Ready_1 = (state_q == IDLE);
    assign o_Valid_1 = (state_q == DONE);
    assign o_Busy_1  = (state_q != IDLE);

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .gclk   (i_Clk_1),
        .grst   (i_Rst_1),
        .clear  (i_Flush_1),
        .start  (accept && iterative),
        .cfg    (cfg),
        .a      (mag1),
        .b      (mag2),
        .done   (core_done),
        .result (core_res)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv: results, latency, stall hold, flush
// and asynchronous reset behaviour.
module tb_alu_muldiv;

    localparam int XLEN = 32;

    localparam logic [19:0] C_ADD    = 20'h80000;
    localparam logic [19:0] C_PC4    = 20'h40000;
    localparam logic [19:0] C_SUB    = 20'h20000;
    localparam logic [19:0] C_SLT    = 20'h10000;
    localparam logic [19:0] C_SLTU   = 20'h08000;
    localparam logic [19:0] C_XOR    = 20'h01000;
    localparam logic [19:0] C_SLL    = 20'h00800;
    localparam logic [19:0] C_SRA    = 20'h00200;
    localparam logic [19:0] C_LUI    = 20'h00100;
    localparam logic [19:0] C_MUL    = 20'h00080;
    localparam logic [19:0] C_MULH   = 20'h00040;
    localparam logic [19:0] C_MULHSU = 20'h00020;
    localparam logic [19:0] C_MULHU  = 20'h00010;
    localparam logic [19:0] C_DIV    = 20'h00008;
    localparam logic [19:0] C_DIVU   = 20'h00004;
    localparam logic [19:0] C_REM    = 20'h00002;
    localparam logic [19:0] C_REMU   = 20'h00001;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            vld = 1'b0;
    logic            res_rdy = 1'b0;
    logic [19:0]     ctrl = '0;
    logic [XLEN-1:0] pc = '0, op1 = '0, op2 = '0;
    logic            ready, valid, busy;
    logic [XLEN-1:0] result, jba, pcp4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .i_Clk_1          (clk),
        .i_Rst_1          (rst),
        .i_Flush_1        (flush),
        .i_Valid_1        (vld),
        .o_Ready_1        (ready),
        .i_ALUControl_20  (ctrl),
        .i_PC             (pc),
        .i_ALUOperand1    (op1),
        .i_ALUOperand2    (op2),
        .o_Valid_1        (valid),
        .i_ResultReady_1  (res_rdy),
        .o_ALUResult      (result),
        .o_JumpBranchAddr (jba),
        .o_PCPlus4        (pcp4),
        .o_Busy_1         (busy)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request at the negedge; it is accepted on the following
    // posedge, after which the inputs are scrambled.
    task automatic issue(input logic [19:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] p);
        @(negedge clk);
        ctrl = c; op1 = a; op2 = b; pc = p; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        ctrl = 20'($urandom); op1 = $urandom; op2 = $urandom; pc = $urandom;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid && lat < 60);
        chk({tag, " lat"}, lat, exp_lat);
    endtask

    task automatic take(input string tag);
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
        chk({tag, " rdy"}, ready, 1);
        chk({tag, " vld"}, valid, 0);
    endtask

    task automatic run(input string tag, input logic [19:0] c, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                       input logic [XLEN-1:0] exp, input int lat);
        issue(c, a, b, p);
        wait_valid(tag, lat);
        chk(tag, result, exp);
        chk({tag, " jba"}, jba, a + b);
        chk({tag, " pc4"}, pcp4, p + 32'd4);
        take(tag);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int rises = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (valid) rises++;
        end
        chk(tag, rises, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst ready", ready, 1);
        chk("rst valid", valid, 0);
        chk("rst busy", busy, 0);
        chk("rst result", result, 0);
        chk("rst jba", jba, 0);
        chk("rst pc4", pcp4, 0);
        rst = 1'b0;

        run("add",    C_ADD,    32'd7,        32'd9,        32'h100,  32'd16,       1);
        run("sub",    C_SUB,    32'd3,        32'd5,        32'h104,  32'hFFFFFFFE, 1);
        run("sra",    C_SRA,    32'h80000000, 32'h21,       32'h108,  32'hC0000000, 1);
        run("sltu",   C_SLTU,   32'd1,        32'hFFFFFFFF, 32'h10C,  32'd1,        1);
        run("slt",    C_SLT,    32'hFFFFFFFF, 32'd1,        32'h110,  32'd1,        1);
        run("sll",    C_SLL,    32'h00000003, 32'h24,       32'h114,  32'h00000030, 1);
        run("xor",    C_XOR,    32'h0000F0F0, 32'h00000FF0, 32'h118,  32'h0000FF00, 1);
        run("lui",    C_LUI,    32'h12345678, 32'hABCDE000, 32'h11C,  32'hABCDE000, 1);
        run("pc4",    C_PC4,    32'd0,        32'd0,        32'h1000, 32'h1004,     1);
        run("multi",  C_ADD | C_REMU, 32'd5,  32'd6,        32'h120,  32'd0,        1);
        run("zero",   20'h0,    32'd5,        32'd6,        32'h124,  32'd0,        1);

        run("mulh",   C_MULH,   32'h80000000, 32'h80000000, 32'h200,  32'h40000000, 33);
        run("mulhu",  C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h204,  32'hFFFFFFFE, 33);
        run("mul",    C_MUL,    32'hFFFFFFFF, 32'd3,        32'h208,  32'hFFFFFFFD, 33);
        run("mulhsu", C_MULHSU, 32'hFFFFFFFF, 32'd2,        32'h20C,  32'hFFFFFFFF, 33);
        run("div",    C_DIV,    32'hFFFFFFF9, 32'd2,        32'h210,  32'hFFFFFFFD, 33);
        run("rem",    C_REM,    32'hFFFFFFF9, 32'd2,        32'h214,  32'hFFFFFFFF, 33);
        run("divu",   C_DIVU,   32'd100,      32'd7,        32'h218,  32'd14,       33);
        run("remu",   C_REMU,   32'd100,      32'd7,        32'h21C,  32'd2,        33);
        run("divu0",  C_DIVU,   32'd5,        32'd0,        32'h220,  32'hFFFFFFFF, 1);
        run("remu0",  C_REMU,   32'd5,        32'd0,        32'h224,  32'd5,        1);
        run("divovf", C_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h228,  32'h80000000, 1);
        run("removf", C_REM,    32'h80000000, 32'hFFFFFFFF, 32'h22C,  32'd0,        1);

        // Result held while the consumer stalls.
        issue(C_ADD, 32'd20, 32'd22, 32'h300);
        wait_valid("hold", 1);
        repeat (10) begin
            @(negedge clk);
            chk("hold result", result, 32'd42);
            chk("hold valid", valid, 1);
            chk("hold ready", ready, 0);
            chk("hold busy", busy, 1);
        end
        take("hold");

        // Flush in IDLE alongside a request: not accepted.
        @(negedge clk);
        ctrl = C_ADD; op1 = 32'd1; op2 = 32'd1; vld = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0; flush = 1'b0;
        chk("idleflush ready", ready, 1);
        quiet("idleflush quiet", 3);

        // Flush partway through a multiply.
        issue(C_MUL, 32'd12345, 32'd678, 32'h400);
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("calc busy", busy, 1);
        chk("calc ready", ready, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush ready", ready, 1);
        chk("flush valid", valid, 0);
        quiet("flush quiet", 40);
        run("postflush", C_ADD, 32'd1, 32'd1, 32'h404, 32'd2, 1);

        // Asynchronous reset partway through a divide.
        issue(C_DIVU, 32'd100, 32'd7, 32'h500);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst ready", ready, 1);
        chk("arst valid", valid, 0);
        chk("arst busy", busy, 0);
        chk("arst result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet("arst quiet", 40);
        run("postrst", C_ADD, 32'd1, 32'd1, 32'h504, 32'd2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
